osc_sweep_ctrl: RTL and testbench

OSC_SWEEP_CTRL -- requirements
Module: osc_sweep_ctrl

---
 rtl/osc_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_osc_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_sweep_ctrl.sv
// Sweeps all 256 stimulus vectors into a combinational loop and counts the vectors that oscillate.
// Each vector takes SETTLE+OBS+1 cycles; done pulses 256*(SETTLE+OBS+1)+1 cycles after start is sampled.
// No backpressure: start is honoured only in IDLE, and abort cancels a sweep on the next edge.
module osc_sweep_ctrl #(
    parameter int SETTLE = 4,
    parameter int OBS    = 8,
    parameter int HIT_TH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       osc_flag,
    output logic [7:0] vec,
    output logic       busy,
    output logic       done,
    output logic [8:0] osc_cnt,
    output logic [7:0] first_vec,
    output logic       first_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_OBSERVE,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] OBS_LAST    = 4'(OBS - 1);
    localparam logic [3:0] HIT_MIN     = 4'(HIT_TH);

    state_t     state, state_nxt;
    logic [1:0] sync_q;
    logic       flag_s;
    logic [3:0] timer, timer_nxt;
    logic [3:0] hit, hit_nxt;
    logic [7:0] vec_nxt;
    logic [8:0] osc_cnt_nxt;
    logic [7:0] first_vec_nxt;
    logic       first_valid_nxt;

    assign flag_s = sync_q[1];
    assign busy   = (state == ST_SETTLE) || (state == ST_OBSERVE) || (state == ST_NEXT);
    assign done   = (state == ST_DONE);

    // osc_flag comes from a free-running loop, so it is never used before two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], osc_flag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= 4'd0;
            hit         <= 4'd0;
            vec         <= 8'd0;
            osc_cnt     <= 9'd0;
            first_vec   <= 8'd0;
            first_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            hit         <= hit_nxt;
            vec         <= vec_nxt;
            osc_cnt     <= osc_cnt_nxt;
            first_vec   <= first_vec_nxt;
            first_valid <= first_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        hit_nxt         = hit;
        vec_nxt         = vec;
        osc_cnt_nxt     = osc_cnt;
        first_vec_nxt   = first_vec;
        first_valid_nxt = first_valid;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    osc_cnt_nxt     = 9'd0;
                    first_vec_nxt   = 8'd0;
                    first_valid_nxt = 1'b0;
                    vec_nxt         = 8'd0;
                    timer_nxt       = 4'd0;
                    state_nxt       = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (timer == SETTLE_LAST) begin
                    timer_nxt = 4'd0;
                    hit_nxt   = 4'd0;
                    state_nxt = ST_OBSERVE;
                end else begin
                    timer_nxt = timer + 4'd1;
                end
            end
            ST_OBSERVE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (flag_s && (hit != 4'hF)) begin
                        hit_nxt = hit + 4'd1;
                    end
                    if (timer == OBS_LAST) begin
                        timer_nxt = 4'd0;
                        state_nxt = ST_NEXT;
                    end else begin
                        timer_nxt = timer + 4'd1;
                    end
                end
            end
            ST_NEXT: begin
                // abort wins: the vector under test is neither classified nor advanced.
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (hit >= HIT_MIN) begin
                        osc_cnt_nxt = osc_cnt + 9'd1;
                        if (!first_valid) begin
                            first_vec_nxt   = vec;
                            first_valid_nxt = 1'b1;
                        end
                    end
                    if (vec == 8'hFF) begin
                        state_nxt = ST_DONE;
                    end else begin
                        vec_nxt   = vec + 8'd1;
                        timer_nxt = 4'd0;
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_osc_sweep_ctrl.sv
// Scoreboarded bench for osc_sweep_ctrl: sweep results are queued at start and checked on done.
module tb_osc_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       osc_flag;
    logic [7:0] vec;
    logic       busy;
    logic       done;
    logic [8:0] osc_cnt;
    logic [7:0] first_vec;
    logic       first_valid;

    int   mode;
    logic manual_flag;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   s_cyc = 0;

    typedef struct {
        int cnt;
        int fv;
        int fvld;
        int vec;
        int lat;
    } exp_t;

    exp_t sb[$];

    osc_sweep_ctrl #(.SETTLE(4), .OBS(8), .HIT_TH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .osc_flag   (osc_flag),
        .vec        (vec),
        .busy       (busy),
        .done       (done),
        .osc_cnt    (osc_cnt),
        .first_vec  (first_vec),
        .first_valid(first_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: tied low, 1: tied high, 2: loop oscillates only at A5/C3, 3: driven by hand
    assign osc_flag = (mode == 1) ? 1'b1 :
                      (mode == 2) ? ((vec == 8'hA5) || (vec == 8'hC3)) :
                      (mode == 3) ? manual_flag : 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout expected=event within budget", nm);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        s_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo(nm);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_vec(input logic [7:0] v, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (vec == v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo(nm);
    endtask

    // Monitor: every done pulse must match the oldest queued sweep expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=done expected=no_done cyc=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - s_cyc + 1, e.lat);
                    chk("done_osc_cnt", osc_cnt, e.cnt);
                    chk("done_first_vec", first_vec, e.fv);
                    chk("done_first_valid", first_valid, e.fvld);
                    chk("done_vec", vec, e.vec);
                    chk("done_busy", busy, 0);
                    @(posedge clk);
                    #1;
                    chk("done_one_cycle", done, 0);
                    chk("after_done_busy", busy, 0);
                    chk("after_done_vec_hold", vec, e.vec);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        mode        = 0;
        manual_flag = 1'b0;
        #12;
        chk("rst_vec", vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_osc_cnt", osc_cnt, 0);
        chk("rst_first_vec", first_vec, 0);
        chk("rst_first_valid", first_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Quiet loop: nothing classified, vec parks at FF.
        mode = 0;
        sb.push_back('{0, 0, 0, 255, 3329});
        pulse_start();
        chk("start_vec", vec, 0);
        chk("start_busy", busy, 1);
        wait_idle("sweep_quiet");

        // Always oscillating: counter must reach 256 exactly.
        mode = 1;
        sb.push_back('{256, 0, 1, 255, 3329});
        pulse_start();
        wait_idle("sweep_all");

        // Only A5 and C3 oscillate.
        mode = 2;
        sb.push_back('{2, 165, 1, 255, 3329});
        pulse_start();
        chk("clear_cnt_on_start", osc_cnt, 0);
        chk("clear_valid_on_start", first_valid, 0);
        wait_idle("sweep_model");

        // HIT_TH boundary: one hit at 10 is rejected, two hits at 11 count.
        mode = 3;
        sb.push_back('{1, 17, 1, 255, 3329});
        pulse_start();
        wait_vec(8'h10, "wait_vec10");
        repeat (6) @(posedge clk);
        #1 manual_flag = 1'b1;
        @(posedge clk);
        #1 manual_flag = 1'b0;
        wait_vec(8'h11, "wait_vec11");
        repeat (6) @(posedge clk);
        #1 manual_flag = 1'b1;
        repeat (2) @(posedge clk);
        #1 manual_flag = 1'b0;
        wait_idle("sweep_threshold");

        // Abort in NEXT of vector 20 discards that vector and leaves results in place.
        mode = 1;
        pulse_start();
        wait_vec(8'h20, "wait_vec20");
        repeat (12) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_osc_cnt", osc_cnt, 32);
        chk("abort_vec", vec, 32);
        chk("abort_first_valid", first_valid, 1);
        chk("abort_first_vec", first_vec, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_stays_idle", busy, 0);
        chk("abort_cnt_hold", osc_cnt, 32);
        sb.push_back('{256, 0, 1, 255, 3329});
        pulse_start();
        chk("restart_clear_cnt", osc_cnt, 0);
        chk("restart_vec", vec, 0);
        wait_idle("sweep_after_abort");

        // Asynchronous reset in the middle of OBSERVE for vector 40.
        mode = 1;
        pulse_start();
        wait_vec(8'h40, "wait_vec40");
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_vec", vec, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_osc_cnt", osc_cnt, 0);
        chk("midrst_first_vec", first_vec, 0);
        chk("midrst_first_valid", first_valid, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mode = 0;
        sb.push_back('{0, 0, 0, 255, 3329});
        pulse_start();
        chk("postrst_vec", vec, 0);
        chk("postrst_busy", busy, 1);
        wait_idle("sweep_after_reset");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
